// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, issues one outstanding read at a time
// on an SRAM-like handshake bus and offers {ce, pc} plus the word to decode.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int unsigned StallBus = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [StallBus-1:0] stall,
  input  logic [32:0]         br_bus,
  output logic [32:0]         if_to_id_bus,
  output logic [31:0]         if_inst,
  output logic                stallreq_from_if,
  output logic                inst_req,
  output logic                inst_wr,
  output logic [31:0]         inst_addr,
  input  logic                inst_addr_ok,
  input  logic                inst_data_ok,
  input  logic [31:0]         inst_rdata
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_hold;
  logic        r_redir;
  logic [31:0] r_redir_addr;
  logic        r_req_pend;

  logic [1:0]  w_state_nxt;
  logic        w_br_e;
  logic [31:0] w_br_addr;
  logic [31:0] w_next_pc;
  logic        w_ce;
  logic [31:0] w_word;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_handoff;
  logic        w_capture;
  logic        w_unused;

  assign w_unused  = ^stall[StallBus-1:2];
  assign w_br_e    = br_bus[32];
  assign w_br_addr = br_bus[31:0];

  // A live branch wins over a redirect captured while decode was stalled.
  assign w_next_pc = w_br_e  ? w_br_addr :
                     r_redir ? r_redir_addr :
                               r_pc + 32'd4;

  // Next state and bus outputs; a handoff may issue the next fetch in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_ce        = 1'b0;
    w_word      = 32'd0;
    w_req       = 1'b0;
    w_addr      = r_pc;
    w_handoff   = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_REQ: begin
        w_req = ~stall[0] | r_req_pend;
        if (w_req && inst_addr_ok) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        w_ce   = inst_data_ok;
        w_word = inst_rdata;
        if (inst_data_ok) begin
          if (stall[1]) begin
            w_state_nxt = S_HOLD;
            w_capture   = 1'b1;
          end else begin
            w_handoff = 1'b1;
          end
        end
      end
      S_HOLD: begin
        w_ce   = 1'b1;
        w_word = r_hold;
        if (!stall[1]) begin
          w_handoff = 1'b1;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
    if (w_handoff) begin
      if (!stall[0]) begin
        w_req       = 1'b1;
        w_addr      = w_next_pc;
        w_state_nxt = inst_addr_ok ? S_WAIT : S_REQ;
      end else begin
        w_state_nxt = S_REQ;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // PC, redirect, hold buffer and request-persistence registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_hold       <= 32'd0;
      r_redir      <= 1'b0;
      r_redir_addr <= 32'd0;
      r_req_pend   <= 1'b0;
    end else begin
      r_req_pend <= w_req & ~inst_addr_ok;
      if (w_handoff) begin
        r_pc    <= w_next_pc;
        r_redir <= 1'b0;
      end else if (w_br_e) begin
        r_redir      <= 1'b1;
        r_redir_addr <= w_br_addr;
      end
      if (w_capture) begin
        r_hold <= inst_rdata;
      end
    end
  end

  assign inst_req         = ~rst & w_req;
  assign inst_wr          = 1'b0;
  assign inst_addr        = w_addr;
  assign if_to_id_bus     = (!rst && w_ce) ? {1'b1, r_pc} : 33'd0;
  assign if_inst          = (!rst && w_ce) ? w_word : 32'd0;
  assign stallreq_from_if = ~rst & (r_state != S_HOLD);

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios followed by random traffic, all
// checked against a program-order fetch model and a single-slot memory model.
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic [31:0] if_inst;
  logic        stallreq_from_if;
  logic        inst_req;
  logic        inst_wr;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RST_PC), .StallBus(6)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_bus(br_bus),
    .if_to_id_bus(if_to_id_bus), .if_inst(if_inst),
    .stallreq_from_if(stallreq_from_if), .inst_req(inst_req), .inst_wr(inst_wr),
    .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Model state: next word in program order, held word, pending branch, memory slot.
  logic [31:0] exp_pc;
  logic        held, bp, pend, slot_v;
  logic [31:0] bpa, slot_a;
  int          slot_cnt;

  logic        s_req, s_ce, s_sreq;
  logic [31:0] s_addr, s_pc, s_inst;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hBFC0_0100) return 32'h3C01_0001;
    return {a[15:0], a[31:16]} ^ 32'h2468_ACE1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, sample away from the edge, check, advance the model.
  task automatic cyc(input logic r, input logic [5:0] s, input logic be,
                     input logic [31:0] ba, input logic aok, input int dly);
    logic        dok, avail, hand, xreq;
    logic [31:0] nxt;
    @(posedge clk);
    #1;
    dok          = !r && slot_v && (slot_cnt == 0);
    rst          = r;
    stall        = s;
    br_bus       = {be, ba};
    inst_addr_ok = aok;
    inst_data_ok = dok;
    inst_rdata   = dok ? mem_word(slot_a) : $urandom;
    #5;
    s_req  = inst_req;
    s_addr = inst_addr;
    s_ce   = if_to_id_bus[32];
    s_pc   = if_to_id_bus[31:0];
    s_inst = if_inst;
    s_sreq = stallreq_from_if;

    avail = !r && (dok || held);
    hand  = avail && !s[1];
    nxt   = be ? ba : (bp ? bpa : exp_pc + 32'd4);
    xreq  = !r && (pend || (!s[0] && (hand || (!slot_v && !held))));

    chk("inst_wr", 32'(inst_wr), 32'd0);
    if (r) begin
      chk("rst_req", 32'(s_req), 32'd0);
      chk("rst_ce", 32'(s_ce), 32'd0);
      chk("rst_pc", s_pc, 32'd0);
      chk("rst_inst", s_inst, 32'd0);
      chk("rst_stallreq", 32'(s_sreq), 32'd0);
      exp_pc = RST_PC;
      held   = 1'b0;
      bp     = 1'b0;
      pend   = 1'b0;
      slot_v = 1'b0;
    end else begin
      chk("req", 32'(s_req), 32'(xreq));
      if (s_req) chk("addr", s_addr, hand ? nxt : exp_pc);
      chk("ce", 32'(s_ce), 32'(avail));
      if (avail) begin
        chk("pc", s_pc, exp_pc);
        chk("inst", s_inst, mem_word(exp_pc));
      end else begin
        chk("idle_pc", s_pc, 32'd0);
        chk("idle_inst", s_inst, 32'd0);
      end
      chk("stallreq", 32'(s_sreq), 32'(!held));

      if (hand) begin
        exp_pc = nxt;
        bp     = 1'b0;
      end else if (be) begin
        bp  = 1'b1;
        bpa = ba;
      end
      held = avail && s[1];
      pend = s_req && !aok;
      if (dok) slot_v = 1'b0;
      else if (slot_v) slot_cnt--;
      if (s_req && aok) begin
        if (slot_v) chk("one_outstanding", 32'(slot_v), 32'd0);
        slot_v   = 1'b1;
        slot_a   = s_addr;
        slot_cnt = dly;
      end
    end
  endtask

  initial begin
    exp_pc = RST_PC; held = 1'b0; bp = 1'b0; bpa = '0; pend = 1'b0;
    slot_v = 1'b0; slot_a = '0; slot_cnt = 0;
    rst = 1'b1; stall = '0; br_bus = '0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;

    cyc(1'b1, 6'd0, 1'b0, 32'd0, 1'b1, 0);
    cyc(1'b1, 6'd0, 1'b0, 32'd0, 1'b1, 0);

    // Reset release against an ideal memory.
    cyc(1'b0, 6'd0, 1'b0, 32'd0, 1'b1, 0);
    chk("d_req0", 32'(s_req), 32'd1);
    chk("d_addr0", s_addr, 32'hBFC0_0000);
    chk("d_ce0", 32'(s_ce), 32'd0);
    cyc(1'b0, 6'd0, 1'b0, 32'd0, 1'b1, 0);
    chk("d_addr1", s_addr, 32'hBFC0_0004);
    chk("d_pc0", s_pc, 32'hBFC0_0000);
    cyc(1'b0, 6'd0, 1'b0, 32'd0, 1'b1, 0);
    chk("d_addr2", s_addr, 32'hBFC0_0008);
    chk("d_pc1", s_pc, 32'hBFC0_0004);

    // Branch arriving on the handoff of BFC00008.
    cyc(1'b0, 6'd0, 1'b1, 32'hBFC0_0100, 1'b1, 0);
    chk("br_pc", s_pc, 32'hBFC0_0008);
    chk("br_addr", s_addr, 32'hBFC0_0100);

    // Decode stall for 4 cycles on word 3C010001.
    cyc(1'b0, 6'b000010, 1'b0, 32'd0, 1'b1, 0);
    chk("hold_inst0", s_inst, 32'h3C01_0001);
    chk("hold_req0", 32'(s_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 6'b000010, 1'b0, 32'd0, 1'b1, 0);
      chk("hold_inst", s_inst, 32'h3C01_0001);
      chk("hold_pc", s_pc, 32'hBFC0_0100);
      chk("hold_req", 32'(s_req), 32'd0);
    end
    cyc(1'b0, 6'd0, 1'b0, 32'd0, 1'b1, 3);
    chk("rel_pc", s_pc, 32'hBFC0_0100);
    chk("rel_req", 32'(s_req), 32'd1);
    chk("rel_addr", s_addr, 32'hBFC0_0104);

    // Branch while the delay-slot read is 3 cycles late.
    cyc(1'b0, 6'd0, 1'b1, 32'h8000_0040, 1'b1, 0);
    chk("ds_ce", 32'(s_ce), 32'd0);
    cyc(1'b0, 6'd0, 1'b0, 32'd0, 1'b1, 0);
    cyc(1'b0, 6'd0, 1'b0, 32'd0, 1'b1, 0);
    cyc(1'b0, 6'd0, 1'b0, 32'd0, 1'b1, 0);
    chk("ds_pc", s_pc, 32'hBFC0_0104);
    chk("ds_addr", s_addr, 32'h8000_0040);

    // Request held through addr_ok=0 and stall[0].
    cyc(1'b0, 6'd0, 1'b0, 32'd0, 1'b0, 0);
    chk("aok_pc", s_pc, 32'h8000_0040);
    chk("aok_req0", 32'(s_req), 32'd1);
    chk("aok_addr0", s_addr, 32'h8000_0044);
    cyc(1'b0, 6'b000001, 1'b0, 32'd0, 1'b0, 0);
    chk("aok_req1", 32'(s_req), 32'd1);
    chk("aok_addr1", s_addr, 32'h8000_0044);
    cyc(1'b0, 6'b000001, 1'b0, 32'd0, 1'b1, 0);
    chk("aok_req2", 32'(s_req), 32'd1);
    chk("aok_addr2", s_addr, 32'h8000_0044);
    cyc(1'b0, 6'b000001, 1'b1, 32'h8000_0010, 1'b1, 0);
    chk("s0_pc", s_pc, 32'h8000_0044);
    chk("s0_req0", 32'(s_req), 32'd0);
    cyc(1'b0, 6'b000001, 1'b0, 32'd0, 1'b1, 0);
    chk("s0_req1", 32'(s_req), 32'd0);
    cyc(1'b0, 6'd0, 1'b0, 32'd0, 1'b1, 2);
    chk("s0_addr", s_addr, 32'h8000_0010);

    // Reset while waiting on 80000010.
    cyc(1'b1, 6'd0, 1'b0, 32'd0, 1'b1, 0);
    cyc(1'b0, 6'd0, 1'b0, 32'd0, 1'b1, 0);
    chk("rr_addr", s_addr, 32'hBFC0_0000);
    chk("rr_ce", 32'(s_ce), 32'd0);

    // PC wrap from FFFFFFFC.
    cyc(1'b0, 6'd0, 1'b1, 32'hFFFF_FFFC, 1'b1, 0);
    chk("rr_pc", s_pc, 32'hBFC0_0000);
    chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
    cyc(1'b0, 6'd0, 1'b0, 32'd0, 1'b1, 0);
    chk("wrap_pc0", s_pc, 32'hFFFF_FFFC);
    chk("wrap_addr1", s_addr, 32'h0000_0000);
    cyc(1'b0, 6'd0, 1'b0, 32'd0, 1'b1, 0);
    chk("wrap_pc1", s_pc, 32'h0000_0000);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      logic        r, be, aok;
      logic [5:0]  s;
      logic [31:0] ba;
      r   = ($urandom_range(0, 149) == 0);
      s   = {4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      be  = ($urandom_range(0, 5) == 0);
      ba  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      aok = ($urandom_range(0, 2) != 0);
      cyc(r, s, be, ba, aok, int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

The instruction-fetch stage of the 5-stage MIPS pipeline. It owns the PC, issues instruction reads over an SRAM-like handshake bus, and offers each fetched word with its PC to the decode stage. It consumes the decode stage's branch bus and applies redirects after the delay-slot instruction. One request is outstanding at a time, with back-to-back issue, so throughput is one instruction per cycle against a zero-wait memory.

## Interface
- RESET_PC, 32'hBFC0_0000, first fetch address after reset
- StallBus, 6, width of the pipeline stall vector
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- stall  in  StallBus  pipeline stall vector
  - stall[0]=1: no new fetch request may start.
  - stall[1]=1: decode does not accept the current offer.
- br_bus  in  33  {br_e, br_addr[31:0]} from decode, combinational, valid in the cycle the branch/jump sits in decode
- if_to_id_bus  out  33  {ce, pc[31:0]}; ce=1 marks a valid offer
- if_inst  out  32  instruction word paired with if_to_id_bus
- stallreq_from_if  out  1  fetch has no word ready (state REQ or WAIT)
- inst_req  out  1  read request
- inst_wr  out  1  constant 0
- inst_addr  out  32  request address, word aligned
- inst_addr_ok  in  1  request accepted this cycle
- inst_data_ok  in  1  read data valid this cycle
- inst_rdata  in  32  read data

## Operation
- Registers:
  - pc_r: address of the in-flight or held word.
  - state: REQ, WAIT or HOLD.
  - hold_r[31:0]: buffered word.
  - redir_r, redir_addr_r: pending redirect.
- next_pc:
  - br_e=1 → br_addr.
  - otherwise redir_r=1 → redir_addr_r.
  - otherwise pc_r+4 (mod 2^32).
- Handoff occurs when a word is offered (ce=1) and stall[1]=0. At handoff:
  - pc_r <= next_pc.
  - redir_r <= 0.
- Redirect capture: br_e=1 in a cycle without handoff sets redir_r=1 and redir_addr_r=br_addr. A later br_e overwrites both.
- Delay slot: the word offered or in flight while the branch sits in decode is the delay slot. It is never discarded.
- REQ:
  - Output: inst_req = ~stall[0]; inst_addr = pc_r; ce = 0.
  - inst_req & inst_addr_ok → WAIT.
  - Once inst_req is asserted it stays asserted, with a stable address, until inst_addr_ok. stall[0] only blocks assertion.
- WAIT:
  - ce = inst_data_ok; if_inst = inst_rdata; pc = pc_r.
  - data_ok & stall[1] → HOLD; hold_r <= inst_rdata.
  - data_ok & ~stall[1] (handoff) & ~stall[0]: inst_req = 1 and inst_addr = next_pc in the same cycle.
    - addr_ok → stay in WAIT.
    - otherwise → REQ.
  - data_ok & ~stall[1] & stall[0] → REQ, inst_req = 0.
  - No data_ok → stay.
- HOLD:
  - Output: ce = 1; if_inst = hold_r; pc = pc_r; no request.
  - ~stall[1] → handoff; next state and early issue follow the same rules as WAIT's handoff.
- When ce=0: if_to_id_bus = 0 and if_inst = 0.

## Timing
- Reset values:
  - state = REQ; pc_r = RESET_PC; redir_r = 0; hold_r = 0.
  - inst_req = 0 while rst=1; if_to_id_bus = 0; if_inst = 0; stallreq_from_if = 0 while rst=1.
- After reset: the first request for RESET_PC is asserted in the first cycle with rst=0, unless stall[0]=1.
- Latency: request accepted in cycle t with data_ok in cycle t+1 → word offered in t+1. Decode latches it at the end of t+1.
- Throughput: with addr_ok constant 1 and data_ok one cycle after acceptance, one handoff per cycle.
- Simultaneous br_e and handoff: the live br_addr is used, and redir_r is not set.
- br_e held for several cycles while decode stalls: idempotent.
- Reset mid-operation (REQ, WAIT or HOLD): all state is dropped. Memory is reset by the same rst, so no stale data_ok follows.
- pc wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- All outputs are combinational from registered state plus the inputs listed above. No combinational path exists from inst_rdata to inst_req.

## Test plan
- Reset release, ideal memory (addr_ok=1, data_ok one cycle later):
  - Requests go out for BFC00000, BFC00004, BFC00008 on consecutive cycles.
  - ce=1 each cycle from cycle 2, with matching pc and rdata.
- Branch on delay-slot handoff: br_e=1 and br_addr=BFC00100 while the BFC00008 word is handed off.
  - BFC00008 is delivered.
  - The next request is BFC00100.
- Late delay slot: br_e=1 and br_addr=80000040 while the delay-slot data_ok is delayed 3 cycles (br_e drops after 1 cycle).
  - The delay-slot word is delivered.
  - The next request is 80000040.
- Decode stall: data_ok with word 3C010001 while stall[1]=1 for 4 cycles.
  - HOLD offers 3C010001 steadily.
  - inst_req=0 throughout.
  - On release, the word is handed off and the next request issues the same cycle.
- stall[0] with addr_ok=0 for 2 cycles: inst_req is held at 1 with a stable address until addr_ok.
  - A stall[0] raised in REQ before assertion keeps inst_req=0.
- rst pulsed in WAIT at pc 80000010: the next request is BFC00000, and ce stays 0 until its data returns.
